// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_stage #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 16,
    parameter int FLUSH_ZERO = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             stateQ, stateD;
    logic [WIDTH-1:0]   mainQ, mainD;
    logic [WIDTH-1:0]   skidQ, skidD;
    logic [CNT_W-1:0]   stallCntQ, stallCntD;
    logic               inFire;

    // Handshake outputs decode only the state register, so no ready path crosses stages.
    assign in_ready  = (stateQ != SKID);
    assign out_valid = (stateQ != EMPTY);
    assign out_data  = mainQ;
    assign stall_cnt = stallCntQ;
    assign occupancy = (stateQ == SKID) ? 2'd2 :
                       (stateQ == FULL) ? 2'd1 : 2'd0;
    assign inFire    = in_valid & in_ready;

    always_comb begin
        stateD    = stateQ;
        mainD     = mainQ;
        skidD     = skidQ;
        stallCntD = stallCntQ;

        unique case (stateQ)
            EMPTY: begin
                if (inFire) begin
                    stateD = FULL;
                    mainD  = in_data;
                end
            end
            FULL: begin
                if (inFire && out_ready) begin
                    mainD = in_data;
                end else if (inFire) begin
                    stateD = SKID;
                    skidD  = in_data;
                end else if (out_ready) begin
                    stateD = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    stateD = FULL;
                    mainD  = skidQ;
                end
            end
            default: begin
                stateD = EMPTY;
            end
        endcase

        // Flush discards any transfer of this cycle; payload is optionally zeroed.
        if (flush) begin
            stateD = EMPTY;
            if (FLUSH_ZERO != 0) begin
                mainD = '0;
                skidD = '0;
            end else begin
                mainD = mainQ;
                skidD = skidQ;
            end
        end

        if (stat_clr) begin
            stallCntD = '0;
        end else if (out_valid && !out_ready && (stallCntQ != {CNT_W{1'b1}})) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            stateQ    <= EMPTY;
            mainQ     <= '0;
            skidQ     <= '0;
            stallCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            mainQ     <= mainD;
            skidQ     <= skidD;
            stallCntQ <= stallCntD;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: the stage is modelled as a 2-deep FIFO queue
// plus a saturating stall counter; directed scenarios are followed by a random soak.
module tb_pipe_skid_stage;

    localparam int WIDTH      = 8;
    localparam int CNT_W      = 3;
    localparam int FLUSH_ZERO = 1;
    localparam int STALL_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             clrn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic             stat_clr;
    logic [CNT_W-1:0] stall_cnt;

    int               total;
    int               bad;
    logic [WIDTH-1:0] expQ[$];
    int               stallModel;
    bit               modelValid;
    bit               expectZero;
    int               monSize;
    logic [WIDTH-1:0] monFront;
    bit               acceptNow;
    logic [WIDTH-1:0] acceptData;

    pipe_skid_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .FLUSH_ZERO(FLUSH_ZERO)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stat_clr(stat_clr),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit r,
                                 input bit f, input bit sc, input bit rst);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        stat_clr  = sc;
        clrn      = rst;
    endtask

    // Stimulus side: a payload accepted in this cycle becomes expected output from the next edge on.
    always @(negedge clk) begin
        acceptNow  = in_valid && in_ready && !flush && !clrn;
        acceptData = in_data;
    end

    always @(posedge clk) begin
        if (acceptNow) expQ.push_back(acceptData);
    end

    // Monitor: compares outputs against the queue model, pops on every output transfer.
    always @(negedge clk) begin
        monSize = expQ.size();
        if (modelValid) begin
            checkOutput("outValid", 32'(out_valid), 32'(monSize > 0));
            checkOutput("inReady", 32'(in_ready), 32'(monSize < 2));
            checkOutput("occupancy", 32'(occupancy), 32'(monSize));
            checkOutput("stallCnt", 32'(stall_cnt), 32'(stallModel));
            if (expectZero) checkOutput("zeroData", 32'(out_data), 32'd0);
            if (monSize > 0 && out_ready && !flush && !clrn) begin
                monFront = expQ.pop_front();
                checkOutput("popData", 32'(out_data), 32'(monFront));
            end else if (monSize > 0) begin
                checkOutput("heldData", 32'(out_data), 32'(expQ[0]));
            end
        end
        if (clrn) begin
            expQ.delete();
            stallModel = 0;
            expectZero = 1'b1;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (stat_clr) stallModel = 0;
            else if (monSize > 0 && !out_ready && stallModel < STALL_MAX) stallModel++;
            expectZero = flush && (FLUSH_ZERO != 0);
            if (flush) expQ.delete();
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        stallModel = 0;
        modelValid = 1'b0;
        expectZero = 1'b0;
        acceptNow  = 1'b0;
        clrn       = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        stat_clr   = 1'b0;

        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        applyStimulus(1, 8'h01, 1, 0, 0, 0);
        applyStimulus(1, 8'h02, 1, 0, 0, 0);
        applyStimulus(1, 8'h03, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("streamReady", 32'(in_ready), 32'd1);
        checkOutput("streamStall", 32'(stall_cnt), 32'd0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);

        applyStimulus(1, 8'h0A, 0, 0, 0, 0);
        applyStimulus(1, 8'h0B, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("skidOcc", 32'(occupancy), 32'd2);
        checkOutput("skidReady", 32'(in_ready), 32'd0);
        checkOutput("skidData", 32'(out_data), 32'h0A);
        checkOutput("skidStall", 32'(stall_cnt), 32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("drainOcc", 32'(occupancy), 32'd0);
        checkOutput("drainStall", 32'(stall_cnt), 32'd2);

        applyStimulus(1, 8'h05, 0, 0, 0, 0);
        applyStimulus(1, 8'h06, 0, 0, 0, 0);
        applyStimulus(1, 8'h0C, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flushValid", 32'(out_valid), 32'd0);
        checkOutput("flushReady", 32'(in_ready), 32'd1);
        checkOutput("flushOcc", 32'(occupancy), 32'd0);
        checkOutput("flushData", 32'(out_data), 32'd0);

        applyStimulus(1, 8'h07, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstOcc", 32'(occupancy), 32'd0);
        checkOutput("rstStall", 32'(stall_cnt), 32'd0);
        checkOutput("rstData", 32'(out_data), 32'd0);

        applyStimulus(1, 8'h09, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("satStall", 32'(stall_cnt), 32'd7);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("clrStall", 32'(stall_cnt), 32'd0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 127) == 0),
                          ($urandom_range(0, 699) == 0));
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
